// File: rtl/ethernet_ip_pkg.sv
// Shared types and constants for the Ethernet/IPv4 test-traffic receive checker.
package ethernet_ip_pkg;

   localparam int unsigned ETH_HDR_BYTES  = 14;
   localparam int unsigned IP_HDR_BYTES   = 20;
   localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

   typedef enum logic [1:0] {
      StEthHdr,
      StIpHdr,
      StPayload,
      StDrop
   } rx_state_e;

   typedef enum logic [2:0] {
      VerdGood,
      VerdTuser,
      VerdLen,
      VerdHdr,
      VerdPayload
   } verdict_e;

endpackage

// File: rtl/ip_hdr_checksum_acc.sv
// Byte-serial IPv4 header checksum accumulator: pairs bytes into big-endian halfwords and
// keeps a ones'-complement running sum.
module ip_hdr_checksum_acc (
   input  logic       clk,
   input  logic       aresetn,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] byte_in,
   output logic       sum_ok
);

   logic        phase_q, phase_d;
   logic [7:0]  hi_q, hi_d;
   logic [16:0] sum_q, sum_d;
   logic [16:0] fold;

   always_comb begin
      phase_d = phase_q;
      hi_d    = hi_q;
      sum_d   = sum_q;
      if (clear) begin
         phase_d = 1'b0;
         hi_d    = 8'h00;
         sum_d   = 17'h0;
      end else if (enable) begin
         if (!phase_q) begin
            hi_d    = byte_in;
            phase_d = 1'b1;
         end else begin
            // End-around carry folded in on every add keeps the sum within 17 bits.
            sum_d   = {1'b0, sum_q[15:0]} + {1'b0, hi_q, byte_in} + {16'h0, sum_q[16]};
            phase_d = 1'b0;
         end
      end
   end

   assign fold   = {1'b0, sum_q[15:0]} + {16'h0, sum_q[16]};
   assign sum_ok = (fold[15:0] == 16'hFFFF);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         phase_q <= 1'b0;
         hi_q    <= 8'h00;
         sum_q   <= 17'h0;
      end else begin
         phase_q <= phase_d;
         hi_q    <= hi_d;
         sum_q   <= sum_d;
      end
   end

endmodule

// File: rtl/ethernet_ip_packet_sink.sv
// Receive-side checker for generated Ethernet/IPv4 test frames: parses headers, checks the
// repeated-ID payload, and keeps saturating verdict and sequence-gap counters.
module ethernet_ip_packet_sink
   import ethernet_ip_pkg::*;
#(
   parameter int unsigned PAYLOAD_WORDS = 11,
   parameter int unsigned CNT_WIDTH     = 32
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tuser,
   input  logic [47:0]          cfg_dest_mac,
   input  logic [15:0]          cfg_ethertype,
   input  logic [31:0]          cfg_dest_ip,
   input  logic                 stats_clear,
   output logic [CNT_WIDTH-1:0] cnt_good,
   output logic [CNT_WIDTH-1:0] cnt_hdr_err,
   output logic [CNT_WIDTH-1:0] cnt_len_err,
   output logic [CNT_WIDTH-1:0] cnt_payload_err,
   output logic [CNT_WIDTH-1:0] cnt_tuser_err,
   output logic [CNT_WIDTH-1:0] cnt_seq_gap,
   output logic [31:0]          last_packet_id,
   output logic                 frame_done,
   output logic                 frame_good
);

   localparam logic [15:0] PAY_START = 16'(ETH_HDR_BYTES + IP_HDR_BYTES);
   localparam logic [15:0] LAST_IDX  = 16'(ETH_HDR_BYTES + IP_HDR_BYTES + 4 * PAYLOAD_WORDS - 1);
   localparam logic [15:0] TOT_LEN   = 16'(IP_HDR_BYTES + 4 * PAYLOAD_WORDS);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   rx_state_e      state_q, state_d;
   verdict_e       verdict_q, verdict_d;
   logic [15:0]    byte_cnt_q, byte_cnt_d;
   logic [15:0]    tot_len_q, tot_len_d;
   logic [23:0]    part_q, part_d;
   logic [31:0]    id_q, id_d;
   logic           hdr_err_q, hdr_err_d;
   logic           pay_err_q, pay_err_d;
   logic           done_q, done_d;
   logic           tready_q;
   logic           armed_q;
   logic [CNT_WIDTH-1:0] good_q, hdr_q, len_q, pay_q, tuser_q, gap_q;
   logic [31:0]    last_id_q;

   logic           beat, hdr_now, pay_now, hdr_acc, pay_acc;
   logic           csum_en, csum_clr, csum_ok;
   logic [1:0]     pos;
   logic [47:0]    mac_shift;
   logic [31:0]    ip_shift, word;

   assign beat      = s_axis_tvalid & tready_q;
   // Payload and dest-IP fields both start two bytes into a 32-bit-aligned index.
   assign pos       = byte_cnt_q[1:0] - 2'd2;
   assign mac_shift = cfg_dest_mac << {byte_cnt_q[2:0], 3'b000};
   assign ip_shift  = cfg_dest_ip << {pos, 3'b000};
   assign word      = {s_axis_tdata, part_q};

   always_comb begin
      state_d    = state_q;
      verdict_d  = verdict_q;
      byte_cnt_d = byte_cnt_q;
      tot_len_d  = tot_len_q;
      part_d     = part_q;
      id_d       = id_q;
      hdr_err_d  = hdr_err_q;
      pay_err_d  = pay_err_q;
      done_d     = 1'b0;
      hdr_now    = 1'b0;
      pay_now    = 1'b0;
      csum_en    = 1'b0;
      csum_clr   = 1'b0;
      hdr_acc    = hdr_err_q;
      pay_acc    = pay_err_q;
      if (beat) begin
         byte_cnt_d = (byte_cnt_q != 16'hFFFF) ? byte_cnt_q + 16'd1 : byte_cnt_q;
         unique case (state_q)
            StEthHdr: begin
               if (byte_cnt_q < 16'd6 && s_axis_tdata != mac_shift[47:40]) hdr_now = 1'b1;
               if (byte_cnt_q == 16'd12 && s_axis_tdata != cfg_ethertype[15:8]) hdr_now = 1'b1;
               if (byte_cnt_q == 16'd13 && s_axis_tdata != cfg_ethertype[7:0]) hdr_now = 1'b1;
               if (byte_cnt_q == 16'(ETH_HDR_BYTES - 1)) state_d = StIpHdr;
            end
            StIpHdr: begin
               csum_en = 1'b1;
               if (byte_cnt_q == 16'd14 && s_axis_tdata != IPV4_VER_IHL) hdr_now = 1'b1;
               if (byte_cnt_q == 16'd16) tot_len_d[15:8] = s_axis_tdata;
               if (byte_cnt_q == 16'd17) tot_len_d[7:0] = s_axis_tdata;
               if (byte_cnt_q >= 16'd30 && s_axis_tdata != ip_shift[31:24]) hdr_now = 1'b1;
               if (byte_cnt_q == PAY_START - 16'd1) state_d = StPayload;
            end
            StPayload: begin
               unique case (pos)
                  2'd0: part_d[7:0]   = s_axis_tdata;
                  2'd1: part_d[15:8]  = s_axis_tdata;
                  2'd2: part_d[23:16] = s_axis_tdata;
                  default: begin
                     if (byte_cnt_q == PAY_START + 16'd3) id_d = word;
                     else if (word != id_q) pay_now = 1'b1;
                  end
               endcase
               if (byte_cnt_q == LAST_IDX) state_d = StDrop;
            end
            StDrop: ;
            default: state_d = StDrop;
         endcase
         hdr_acc = hdr_err_q | hdr_now;
         pay_acc = pay_err_q | pay_now;
         hdr_err_d = hdr_acc;
         pay_err_d = pay_acc;
         if (s_axis_tlast) begin
            if (s_axis_tuser)
               verdict_d = VerdTuser;
            else if (byte_cnt_q != LAST_IDX || tot_len_d != TOT_LEN)
               verdict_d = VerdLen;
            else if (hdr_acc || !csum_ok)
               verdict_d = VerdHdr;
            else if (pay_acc)
               verdict_d = VerdPayload;
            else
               verdict_d = VerdGood;
            done_d     = 1'b1;
            state_d    = StEthHdr;
            byte_cnt_d = 16'd0;
            tot_len_d  = 16'd0;
            hdr_err_d  = 1'b0;
            pay_err_d  = 1'b0;
            csum_clr   = 1'b1;
         end
      end
   end

   ip_hdr_checksum_acc u_csum (
      .clk     (clk),
      .aresetn (aresetn),
      .clear   (csum_clr),
      .enable  (csum_en),
      .byte_in (s_axis_tdata),
      .sum_ok  (csum_ok)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= StEthHdr;
         verdict_q  <= VerdGood;
         byte_cnt_q <= 16'd0;
         tot_len_q  <= 16'd0;
         part_q     <= 24'h0;
         id_q       <= 32'h0;
         hdr_err_q  <= 1'b0;
         pay_err_q  <= 1'b0;
         done_q     <= 1'b0;
         tready_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         verdict_q  <= verdict_d;
         byte_cnt_q <= byte_cnt_d;
         tot_len_q  <= tot_len_d;
         part_q     <= part_d;
         id_q       <= id_d;
         hdr_err_q  <= hdr_err_d;
         pay_err_q  <= pay_err_d;
         done_q     <= done_d;
         tready_q   <= 1'b1;
      end
   end

   // Counters are committed at the end of the frame_done cycle so a coincident clear wins.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         good_q    <= '0;
         hdr_q     <= '0;
         len_q     <= '0;
         pay_q     <= '0;
         tuser_q   <= '0;
         gap_q     <= '0;
         last_id_q <= 32'h0;
         armed_q   <= 1'b0;
      end else if (stats_clear) begin
         good_q  <= '0;
         hdr_q   <= '0;
         len_q   <= '0;
         pay_q   <= '0;
         tuser_q <= '0;
         gap_q   <= '0;
         armed_q <= 1'b0;
      end else if (done_q) begin
         unique case (verdict_q)
            VerdTuser:   tuser_q <= sat_inc(tuser_q);
            VerdLen:     len_q   <= sat_inc(len_q);
            VerdHdr:     hdr_q   <= sat_inc(hdr_q);
            VerdPayload: pay_q   <= sat_inc(pay_q);
            default: begin
               good_q <= sat_inc(good_q);
               if (armed_q && id_q != last_id_q + 32'd1) gap_q <= sat_inc(gap_q);
               last_id_q <= id_q;
               armed_q   <= 1'b1;
            end
         endcase
      end
   end

   assign s_axis_tready   = tready_q;
   assign cnt_good        = good_q;
   assign cnt_hdr_err     = hdr_q;
   assign cnt_len_err     = len_q;
   assign cnt_payload_err = pay_q;
   assign cnt_tuser_err   = tuser_q;
   assign cnt_seq_gap     = gap_q;
   assign last_packet_id  = last_id_q;
   assign frame_done      = done_q;
   assign frame_good      = done_q && (verdict_q == VerdGood);

endmodule

// File: tb/tb_ethernet_ip_packet_sink.sv
// Directed self-checking bench for ethernet_ip_packet_sink using hand-built 78-byte frames.
module tb_ethernet_ip_packet_sink;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
   logic [47:0] cfg_dest_mac;
   logic [15:0] cfg_ethertype;
   logic [31:0] cfg_dest_ip;
   logic        stats_clear;
   logic [31:0] cnt_good, cnt_hdr_err, cnt_len_err, cnt_payload_err, cnt_tuser_err, cnt_seq_gap;
   logic [31:0] last_packet_id;
   logic        frame_done, frame_good;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] frm [0:127];

   always #5 clk = ~clk;

   ethernet_ip_packet_sink dut (
      .clk             (clk),
      .aresetn         (aresetn),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tuser    (s_axis_tuser),
      .cfg_dest_mac    (cfg_dest_mac),
      .cfg_ethertype   (cfg_ethertype),
      .cfg_dest_ip     (cfg_dest_ip),
      .stats_clear     (stats_clear),
      .cnt_good        (cnt_good),
      .cnt_hdr_err     (cnt_hdr_err),
      .cnt_len_err     (cnt_len_err),
      .cnt_payload_err (cnt_payload_err),
      .cnt_tuser_err   (cnt_tuser_err),
      .cnt_seq_gap     (cnt_seq_gap),
      .last_packet_id  (last_packet_id),
      .frame_done      (frame_done),
      .frame_good      (frame_good)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Header checksum B759 is precomputed by hand for this fixed header.
   task automatic build(input logic [31:0] id);
      logic [7:0] hdr [0:33];
      hdr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00,
              8'h40, 8'h11, 8'hB7, 8'h59, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'hC0, 8'hA8, 8'h01,
              8'h02};
      for (int i = 0; i < 34; i++) frm[i] = hdr[i];
      for (int w = 0; w < 11; w++)
         for (int b = 0; b < 4; b++) frm[34 + 4 * w + b] = id[8 * b +: 8];
   endtask

   task automatic send(input int n, input logic tu, input logic clr, input logic exp_good);
      for (int i = 0; i < n; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = frm[i];
         s_axis_tlast  = (i == n - 1);
         s_axis_tuser  = (i == n - 1) ? tu : 1'b0;
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      check_eq("frame_done", {31'h0, frame_done}, 32'd1);
      check_eq("frame_good", {31'h0, frame_good}, {31'h0, exp_good});
      if (clr) stats_clear = 1'b1;
      @(posedge clk);
      #1;
      stats_clear = 1'b0;
      check_eq("frame_done_pulse", {31'h0, frame_done}, 32'd0);
   endtask

   task automatic pulse_clear();
      stats_clear = 1'b1;
      @(posedge clk);
      #1;
      stats_clear = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn       = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      cfg_dest_mac  = 48'h02_00_00_00_00_01;
      cfg_ethertype = 16'h0800;
      cfg_dest_ip   = 32'hC0A8_0102;
      stats_clear   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tready", {31'h0, s_axis_tready}, 32'd0);
      check_eq("rst_good", cnt_good, 32'd0);
      check_eq("rst_last_id", last_packet_id, 32'd0);
      check_eq("rst_done", {31'h0, frame_done}, 32'd0);
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      check_eq("tready_after_rst", {31'h0, s_axis_tready}, 32'd1);

      build(32'd5);
      send(78, 1'b0, 1'b0, 1'b1);
      check_eq("good_id5", cnt_good, 32'd1);
      check_eq("last_id5", last_packet_id, 32'd5);
      check_eq("gap_id5", cnt_seq_gap, 32'd0);

      pulse_clear();
      check_eq("clear_good", cnt_good, 32'd0);
      build(32'd7);  send(78, 1'b0, 1'b0, 1'b1);
      build(32'd8);  send(78, 1'b0, 1'b0, 1'b1);
      build(32'd10); send(78, 1'b0, 1'b0, 1'b1);
      check_eq("seq_good3", cnt_good, 32'd3);
      check_eq("seq_gap1", cnt_seq_gap, 32'd1);
      build(32'hFFFF_FFFF); send(78, 1'b0, 1'b0, 1'b1);
      check_eq("seq_gap_ffff", cnt_seq_gap, 32'd2);
      build(32'd0); send(78, 1'b0, 1'b0, 1'b1);
      check_eq("seq_wrap_nogap", cnt_seq_gap, 32'd2);
      check_eq("last_id_wrap", last_packet_id, 32'd0);

      pulse_clear();
      build(32'd3); send(41, 1'b0, 1'b0, 1'b0);
      check_eq("len_trunc", cnt_len_err, 32'd1);
      build(32'd4); send(78, 1'b0, 1'b0, 1'b1);
      check_eq("resync_good", cnt_good, 32'd1);
      build(32'd5); send(79, 1'b0, 1'b0, 1'b0);
      check_eq("len_long", cnt_len_err, 32'd2);
      build(32'd6); frm[17] = 8'h41; send(78, 1'b0, 1'b0, 1'b0);
      check_eq("len_totlen", cnt_len_err, 32'd3);
      check_eq("totlen_not_hdr", cnt_hdr_err, 32'd0);

      build(32'd6); frm[24] = frm[24] ^ 8'h01; send(78, 1'b0, 1'b0, 1'b0);
      check_eq("hdr_csum", cnt_hdr_err, 32'd1);
      build(32'd7); frm[0] = 8'h03; send(78, 1'b0, 1'b0, 1'b0);
      check_eq("hdr_mac", cnt_hdr_err, 32'd2);
      build(32'd8); frm[32] = 8'h09; frm[26] = 8'hC8; send(78, 1'b0, 1'b0, 1'b0);
      check_eq("hdr_ip", cnt_hdr_err, 32'd3);

      build(32'd8); frm[46] = frm[46] ^ 8'h01; send(78, 1'b0, 1'b0, 1'b0);
      check_eq("payload_err", cnt_payload_err, 32'd1);
      send(78, 1'b1, 1'b0, 1'b0);
      check_eq("tuser_err", cnt_tuser_err, 32'd1);
      check_eq("tuser_not_payload", cnt_payload_err, 32'd1);
      check_eq("good_unchanged", cnt_good, 32'd1);

      build(32'd9); send(78, 1'b0, 1'b1, 1'b1);
      check_eq("clr_done_good", cnt_good, 32'd0);
      check_eq("clr_done_len", cnt_len_err, 32'd0);
      check_eq("clr_done_hdr", cnt_hdr_err, 32'd0);
      check_eq("clr_done_pay", cnt_payload_err, 32'd0);
      check_eq("clr_done_tuser", cnt_tuser_err, 32'd0);
      build(32'd99); send(78, 1'b0, 1'b0, 1'b1);
      check_eq("post_clr_good", cnt_good, 32'd1);
      check_eq("post_clr_gap", cnt_seq_gap, 32'd0);
      check_eq("post_clr_last_id", last_packet_id, 32'd99);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
